// File: rtl/comp_icache_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// comp_icache_ctrl_pkg
//   Shared definitions for the compressing instruction-fetch controller:
//   field and key widths, cache geometry, FSM state encoding, the packed key
//   triple stored per cache line, and helpers that slice an instruction word
//   into its three dictionary fields and split a fetch address.
// -----------------------------------------------------------------------------
package comp_icache_ctrl_pkg;

  // Instruction field widths: field1 = instr[6:0], field2 = instr[16:7],
  // field3 = instr[31:17].
  localparam int F1_VAL_W = 7;
  localparam int F2_VAL_W = 10;
  localparam int F3_VAL_W = 15;

  // Dictionary index widths (8, 32 and 256 entries).
  localparam int F1_KEY_W = 3;
  localparam int F2_KEY_W = 5;
  localparam int F3_KEY_W = 8;
  localparam int KEY_W    = F1_KEY_W + F2_KEY_W + F3_KEY_W;

  // Direct-mapped cache geometry over word-aligned byte addresses.
  localparam int LINES = 16;
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Compressed form of one instruction: {k3, k2, k1}.
  typedef struct packed {
    logic [F3_KEY_W-1:0] k3;
    logic [F2_KEY_W-1:0] k2;
    logic [F1_KEY_W-1:0] k1;
  } key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [F1_VAL_W-1:0] field1(input logic [31:0] w);
    return w[F1_VAL_W-1:0];
  endfunction

  function automatic logic [F2_VAL_W-1:0] field2(input logic [31:0] w);
    return w[F1_VAL_W+F2_VAL_W-1:F1_VAL_W];
  endfunction

  function automatic logic [F3_VAL_W-1:0] field3(input logic [31:0] w);
    return w[31:F1_VAL_W+F2_VAL_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
    return a[IDX_W+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[31:IDX_W+2];
  endfunction

endpackage

// File: rtl/comp_icache_ctrl_field_dict.sv
// -----------------------------------------------------------------------------
// field_dict
//   One programmable value dictionary. Entries are filled sequentially through
//   a wrapping write pointer, looked up associatively (lowest matching index
//   wins) and read back by index for decompression. Neither the storage nor
//   the write pointer is touched by the controller reset, so software-loaded
//   dictionaries survive a core reset.
//
//   Ports:
//     clk           clock
//     i_wr_en       write i_wr_val at the write pointer, then advance it
//     i_wr_val      value to store
//     i_lookup_val  value to search for
//     o_hit         some entry equals i_lookup_val
//     o_key         lowest index whose entry equals i_lookup_val
//     i_rd_key      index for the read port
//     o_rd_val      entry stored at i_rd_key
// -----------------------------------------------------------------------------
module field_dict #(
  parameter int VAL_W = 7,
  parameter int KEY_W = 3
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [VAL_W-1:0] i_wr_val,
  input  logic [VAL_W-1:0] i_lookup_val,
  output logic             o_hit,
  output logic [KEY_W-1:0] o_key,
  input  logic [KEY_W-1:0] i_rd_key,
  output logic [VAL_W-1:0] o_rd_val
);

  localparam int DEPTH = 1 << KEY_W;

  logic [VAL_W-1:0] r_mem [DEPTH];
  logic [KEY_W-1:0] r_wr_ptr;

  // NOTE: storage and pointer have no reset branch on purpose: clearing a
  // memory costs a write port per entry, and these contents must outlive
  // resetn. Their power-up value comes from the device configuration.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      // NOTE: sequential state is always written with <= so every flop in the
      // design samples the pre-edge values regardless of statement order.
      r_mem[r_wr_ptr] <= i_wr_val;
      r_wr_ptr        <= r_wr_ptr + 1'b1;  // wraps naturally at DEPTH
    end
  end

  // Scan from the top down so the lowest matching index is the last to write
  // o_key and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a
    // path that leaves one unassigned would infer a latch.
    o_hit = 1'b0;
    o_key = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_mem[i] == i_lookup_val) begin
        o_hit = 1'b1;
        o_key = KEY_W'(i);
      end
    end
  end

  assign o_rd_val = r_mem[i_rd_key];

endmodule

// File: rtl/comp_icache_ctrl.sv
// -----------------------------------------------------------------------------
// comp_icache_ctrl
//   Instruction-fetch controller between the picorv32 instruction port and the
//   instruction memory. Fetched words whose three fields are all present in
//   the dictionaries are cached as 16-bit key triples in a direct-mapped
//   cache; a hit is rebuilt from the dictionaries without a memory access.
//   Words that cannot be compressed are always fetched from memory.
//
//   Ports:
//     clk, resetn               clock, synchronous active-low reset
//     proc_valid/ready          fetch request (held) / one-cycle response
//     proc_addr, proc_rdata     word-aligned fetch address / instruction
//     mem_req_valid/ready       imem request (held) / response strobe
//     mem_req_addr/rdata        imem address (= proc_addr) / imem data
//     dictN_write_enable/val    sequential dictionary fill, N = 1..3
//     debug_comp_cache_miss     one-cycle pulse per cache miss
//     debug_comp_occupancy      number of valid cache lines
//     debug_compressible        last memory fill was compressible
//     debug_decompressed_instr  last word returned to the processor
// -----------------------------------------------------------------------------
module comp_icache_ctrl
  import comp_icache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                proc_valid,
  output logic                proc_ready,
  input  logic [31:0]         proc_addr,
  output logic [31:0]         proc_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_req_addr,
  input  logic [31:0]         mem_req_rdata,
  input  logic                dict1_write_enable,
  input  logic [F1_VAL_W-1:0] dict1_write_val,
  input  logic                dict2_write_enable,
  input  logic [F2_VAL_W-1:0] dict2_write_val,
  input  logic                dict3_write_enable,
  input  logic [F3_VAL_W-1:0] dict3_write_val,
  output logic                debug_comp_cache_miss,
  output logic [31:0]         debug_comp_occupancy,
  output logic                debug_compressible,
  output logic [31:0]         debug_decompressed_instr
);

  state_t r_state, w_state_nxt;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];
  key_t             r_key [LINES];

  logic [31:0]      r_proc_rdata;
  logic [31:0]      r_decomp;
  logic [31:0]      r_occupancy;
  logic             r_miss;
  logic             r_compressible;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  key_t             w_line_key;
  key_t             w_fill_key;
  logic             w_hit1, w_hit2, w_hit3;
  logic             w_compressible;
  logic             w_fill;
  logic [F1_VAL_W-1:0] w_rd1;
  logic [F2_VAL_W-1:0] w_rd2;
  logic [F3_VAL_W-1:0] w_rd3;
  logic [31:0]      w_hit_word;
  logic             w_unused_addr_lsbs;

  // Byte offset within the word is always zero for instruction fetches.
  assign w_unused_addr_lsbs = ^proc_addr[1:0];

  assign w_idx = addr_idx(proc_addr);
  assign w_tag = addr_tag(proc_addr);
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_line_key = r_key[w_idx];

  // Lookup side compresses the word arriving from memory; read side expands
  // the key stored in the addressed line.
  field_dict #(.VAL_W(F1_VAL_W), .KEY_W(F1_KEY_W)) u_dict1 (
    .clk          (clk),
    .i_wr_en      (dict1_write_enable),
    .i_wr_val     (dict1_write_val),
    .i_lookup_val (field1(mem_req_rdata)),
    .o_hit        (w_hit1),
    .o_key        (w_fill_key.k1),
    .i_rd_key     (w_line_key.k1),
    .o_rd_val     (w_rd1)
  );

  field_dict #(.VAL_W(F2_VAL_W), .KEY_W(F2_KEY_W)) u_dict2 (
    .clk          (clk),
    .i_wr_en      (dict2_write_enable),
    .i_wr_val     (dict2_write_val),
    .i_lookup_val (field2(mem_req_rdata)),
    .o_hit        (w_hit2),
    .o_key        (w_fill_key.k2),
    .i_rd_key     (w_line_key.k2),
    .o_rd_val     (w_rd2)
  );

  field_dict #(.VAL_W(F3_VAL_W), .KEY_W(F3_KEY_W)) u_dict3 (
    .clk          (clk),
    .i_wr_en      (dict3_write_enable),
    .i_wr_val     (dict3_write_val),
    .i_lookup_val (field3(mem_req_rdata)),
    .o_hit        (w_hit3),
    .o_key        (w_fill_key.k3),
    .i_rd_key     (w_line_key.k3),
    .o_rd_val     (w_rd3)
  );

  assign w_compressible = w_hit1 && w_hit2 && w_hit3;
  assign w_hit_word     = {w_rd3, w_rd2, w_rd1};
  assign w_fill         = (r_state == ST_MEM) && mem_req_ready && w_compressible;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    proc_ready    = 1'b0;
    mem_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (proc_valid) w_state_nxt = w_hit ? ST_RESP : ST_MEM;
      end
      ST_MEM: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        proc_ready  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mem_req_addr = proc_addr;

  // ------------------------------------------------------ datapath/debug
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid        <= '0;
      r_proc_rdata   <= '0;
      r_decomp       <= '0;
      r_occupancy    <= '0;
      r_miss         <= 1'b0;
      r_compressible <= 1'b0;
    end else begin
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (proc_valid) begin
            if (w_hit) begin
              r_proc_rdata <= w_hit_word;
              r_decomp     <= w_hit_word;
            end else begin
              r_miss <= 1'b1;
            end
          end
        end
        ST_MEM: begin
          if (mem_req_ready) begin
            r_proc_rdata   <= mem_req_rdata;
            r_decomp       <= mem_req_rdata;
            r_compressible <= w_compressible;
            if (w_compressible) begin
              r_valid[w_idx] <= 1'b1;
              // Replacing a valid line keeps the count; only new lines add.
              if (!r_valid[w_idx]) r_occupancy <= r_occupancy + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and key arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_idx] <= w_tag;
      r_key[w_idx] <= w_fill_key;
    end
  end

  assign proc_rdata               = r_proc_rdata;
  assign debug_comp_cache_miss    = r_miss;
  assign debug_comp_occupancy     = r_occupancy;
  assign debug_compressible       = r_compressible;
  assign debug_decompressed_instr = r_decomp;

endmodule

// File: tb/tb_comp_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comp_icache_ctrl
//   Directed bench for comp_icache_ctrl. A small address-indexed table stands
//   in for the instruction memory, with a per-fetch response latency. Inputs
//   change 1 ns after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_comp_icache_ctrl;

  logic        clk;
  logic        resetn;
  logic        proc_valid;
  logic        proc_ready;
  logic [31:0] proc_addr;
  logic [31:0] proc_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        dict1_write_enable;
  logic [6:0]  dict1_write_val;
  logic        dict2_write_enable;
  logic [9:0]  dict2_write_val;
  logic        dict3_write_enable;
  logic [14:0] dict3_write_val;
  logic        debug_comp_cache_miss;
  logic [31:0] debug_comp_occupancy;
  logic        debug_compressible;
  logic [31:0] debug_decompressed_instr;

  int n_vec;
  int n_miscompare;

  comp_icache_ctrl dut (
    .clk                      (clk),
    .resetn                   (resetn),
    .proc_valid               (proc_valid),
    .proc_ready               (proc_ready),
    .proc_addr                (proc_addr),
    .proc_rdata               (proc_rdata),
    .mem_req_valid            (mem_req_valid),
    .mem_req_ready            (mem_req_ready),
    .mem_req_addr             (mem_req_addr),
    .mem_req_rdata            (mem_req_rdata),
    .dict1_write_enable       (dict1_write_enable),
    .dict1_write_val          (dict1_write_val),
    .dict2_write_enable       (dict2_write_enable),
    .dict2_write_val          (dict2_write_val),
    .dict3_write_enable       (dict3_write_enable),
    .dict3_write_val          (dict3_write_val),
    .debug_comp_cache_miss    (debug_comp_cache_miss),
    .debug_comp_occupancy     (debug_comp_occupancy),
    .debug_compressible       (debug_compressible),
    .debug_decompressed_instr (debug_decompressed_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Instruction memory contents.
  //   0x00: 0x00000013  fields 0x13 / 0x000 / 0x0000
  //   0x04: 0xFFFFFFFF  field1 0x7F is in no dictionary
  //   0x08: 0x00016637  fields 0x37 / 0x2CC / 0x0000
  //   0x0C: 0x00000013
  //   0x40: 0x246852B3  fields 0x33 / 0x0A5 / 0x1234
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0013;
      32'h0000_0004: return 32'hFFFF_FFFF;
      32'h0000_0008: return 32'h0001_6637;
      32'h0000_000C: return 32'h0000_0013;
      32'h0000_0040: return 32'h2468_52B3;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic dict_wr(input int n, input logic [14:0] v);
    case (n)
      1: begin dict1_write_enable = 1'b1; dict1_write_val = v[6:0]; end
      2: begin dict2_write_enable = 1'b1; dict2_write_val = v[9:0]; end
      default: begin dict3_write_enable = 1'b1; dict3_write_val = v; end
    endcase
    @(posedge clk); #1;
    dict1_write_enable = 1'b0;
    dict2_write_enable = 1'b0;
    dict3_write_enable = 1'b0;
  endtask

  // One complete fetch. exp_miss selects the expected path; a hit answers one
  // cycle after the request, a miss answers lat + 2 cycles after it.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input int lat,
                          input logic [31:0] exp_data, input bit exp_miss);
    logic [31:0] data;
    int cyc, miss_cnt, wait_n, exp_cyc;
    bit saw_mem, drop_err, addr_err, done, prev_ready;
    data = '0; cyc = 0; miss_cnt = 0; wait_n = 0;
    saw_mem = 0; drop_err = 0; addr_err = 0; done = 0;
    exp_cyc = exp_miss ? lat + 2 : 1;
    proc_addr  = addr;
    proc_valid = 1'b1;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      prev_ready = mem_req_ready;
      if (prev_ready && mem_req_valid) drop_err = 1;
      mem_req_ready = 1'b0;
      if (debug_comp_cache_miss) miss_cnt++;
      if (mem_req_valid) begin
        saw_mem = 1;
        if (mem_req_addr !== addr) addr_err = 1;
        if (wait_n == lat) begin
          mem_req_ready = 1'b1;
          mem_req_rdata = imem(mem_req_addr);
        end
        wait_n++;
      end
      if (proc_ready) begin
        data = proc_rdata;
        done = 1;
      end
    end
    proc_valid    = 1'b0;
    mem_req_ready = 1'b0;
    check({tag, ":responded"},   32'(done),     32'd1);
    check({tag, ":rdata"},       data,          exp_data);
    check({tag, ":mem_access"},  32'(saw_mem),  32'(exp_miss));
    check({tag, ":miss_pulses"}, 32'(miss_cnt), 32'(exp_miss));
    check({tag, ":latency"},     32'(cyc),      32'(exp_cyc));
    check({tag, ":mem_addr"},    32'(addr_err), 32'd0);
    check({tag, ":valid_drop"},  32'(drop_err), 32'd0);
    check({tag, ":dbg_instr"},   debug_decompressed_instr, exp_data);
    @(posedge clk); #1;
    check({tag, ":ready_1cyc"},  32'(proc_ready), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_miscompare = 0;
    resetn = 1'b0;
    proc_valid = 1'b0;
    proc_addr = '0;
    mem_req_ready = 1'b0;
    mem_req_rdata = '0;
    dict1_write_enable = 1'b0; dict1_write_val = '0;
    dict2_write_enable = 1'b0; dict2_write_val = '0;
    dict3_write_enable = 1'b0; dict3_write_val = '0;
    @(posedge clk); #1;

    // dict1 = {0x13, 0x33, 0x37, ...}, written while reset is asserted.
    dict_wr(1, 15'h13);
    dict_wr(1, 15'h33);
    dict_wr(1, 15'h37);
    check("rst:proc_ready", 32'(proc_ready),            32'd0);
    check("rst:mem_valid",  32'(mem_req_valid),         32'd0);
    check("rst:miss",       32'(debug_comp_cache_miss), 32'd0);
    check("rst:occupancy",  debug_comp_occupancy,       32'd0);
    check("rst:compress",   32'(debug_compressible),    32'd0);
    check("rst:dbg_instr",  debug_decompressed_instr,   32'd0);
    check("rst:rdata",      proc_rdata,                 32'd0);
    resetn = 1'b1;

    // dict2 = {0x000, 0x0A5, ...}; dict3 = {0x0000, 0x1234, ...}
    dict_wr(2, 15'h000);
    dict_wr(2, 15'h0A5);
    dict_wr(3, 15'h0000);
    dict_wr(3, 15'h1234);

    // 1: first fetch of a compressible word.
    do_fetch("t1_miss", 32'h0, 0, 32'h0000_0013, 1'b1);
    check("t1:compress",  32'(debug_compressible), 32'd1);
    check("t1:occupancy", debug_comp_occupancy,    32'd1);

    // 2: re-fetch hits and is rebuilt from the dictionaries.
    do_fetch("t2_hit", 32'h0, 0, 32'h0000_0013, 1'b0);

    // 3: incompressible word always goes to memory.
    do_fetch("t3_a", 32'h4, 2, 32'hFFFF_FFFF, 1'b1);
    check("t3a:compress",  32'(debug_compressible), 32'd0);
    check("t3a:occupancy", debug_comp_occupancy,    32'd1);
    do_fetch("t3_b", 32'h4, 3, 32'hFFFF_FFFF, 1'b1);
    check("t3b:compress",  32'(debug_compressible), 32'd0);
    check("t3b:occupancy", debug_comp_occupancy,    32'd1);

    // 4: 0x0 and 0x40 share line 0 with different tags.
    do_fetch("t4_hit0",  32'h0,  0, 32'h0000_0013, 1'b0);
    do_fetch("t4_miss40", 32'h40, 1, 32'h2468_52B3, 1'b1);
    check("t4:compress40",  32'(debug_compressible), 32'd1);
    check("t4:occupancy40", debug_comp_occupancy,    32'd1);
    do_fetch("t4_hit40", 32'h40, 0, 32'h2468_52B3, 1'b0);
    do_fetch("t4_miss0", 32'h0,  0, 32'h0000_0013, 1'b1);
    check("t4:occupancy0",  debug_comp_occupancy,    32'd1);

    // 5: value 0x2CC at dict2[3] and dict2[7]; the lowest index is stored.
    dict_wr(2, 15'h111);  // [2]
    dict_wr(2, 15'h2CC);  // [3]
    dict_wr(2, 15'h111);  // [4]
    dict_wr(2, 15'h111);  // [5]
    dict_wr(2, 15'h111);  // [6]
    dict_wr(2, 15'h2CC);  // [7]
    do_fetch("t5_miss", 32'h8, 0, 32'h0001_6637, 1'b1);
    check("t5:compress",  32'(debug_compressible), 32'd1);
    check("t5:occupancy", debug_comp_occupancy,    32'd2);
    do_fetch("t5_hit", 32'h8, 0, 32'h0001_6637, 1'b0);
    // Wrap the pointer and change dict2[3] to 0x155: a line holding k2=3 now
    // expands to {0x0000, 0x155, 0x37} = 0x0000AAB7.
    for (int i = 8; i < 32; i++) dict_wr(2, 15'h111);
    dict_wr(2, 15'h000);  // [0]
    dict_wr(2, 15'h0A5);  // [1]
    dict_wr(2, 15'h111);  // [2]
    dict_wr(2, 15'h155);  // [3]
    do_fetch("t5_key3", 32'h8, 0, 32'h0000_AAB7, 1'b0);

    // 6: reset while the memory request is outstanding.
    proc_addr  = 32'hC;
    proc_valid = 1'b1;
    @(posedge clk); #1;
    check("t6:mem_valid", 32'(mem_req_valid),         32'd1);
    check("t6:miss",      32'(debug_comp_cache_miss), 32'd1);
    @(posedge clk); #1;
    check("t6:mem_held",  32'(mem_req_valid),         32'd1);
    check("t6:miss_1cyc", 32'(debug_comp_cache_miss), 32'd0);
    resetn     = 1'b0;
    proc_valid = 1'b0;
    @(posedge clk); #1;
    check("t6:abort_valid", 32'(mem_req_valid),      32'd0);
    check("t6:abort_occ",   debug_comp_occupancy,    32'd0);
    check("t6:abort_comp",  32'(debug_compressible), 32'd0);
    check("t6:abort_rdata", proc_rdata,              32'd0);
    resetn = 1'b1;
    // A late response while idle must be ignored.
    mem_req_ready = 1'b1;
    mem_req_rdata = 32'h0000_0013;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("t6:late_ready", 32'(proc_ready),    32'd0);
    check("t6:late_valid", 32'(mem_req_valid), 32'd0);
    check("t6:late_occ",   debug_comp_occupancy, 32'd0);
    @(posedge clk); #1;
    check("t6:late_idle",  32'(proc_ready),    32'd0);
    // Valid bits are gone but dictionaries survive.
    do_fetch("t6_refetch0", 32'h0, 0, 32'h0000_0013, 1'b1);
    check("t6:compress0",  32'(debug_compressible), 32'd1);
    check("t6:occupancy0", debug_comp_occupancy,    32'd1);
    do_fetch("t6_hit0", 32'h0, 0, 32'h0000_0013, 1'b0);
    // 0x2CC now only matches dict2[7].
    do_fetch("t6_refetch8", 32'h8, 1, 32'h0001_6637, 1'b1);
    check("t6:compress8",  32'(debug_compressible), 32'd1);
    check("t6:occupancy8", debug_comp_occupancy,    32'd2);
    do_fetch("t6_hit8", 32'h8, 0, 32'h0001_6637, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
